ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to a keyboard or mouse on PS2_CLK/PS2_DAT. It is the counterpart of the PS/2 receive path. The top level wires its open-drain enables to the PS2_CLK/PS2_DAT inouts: a line is driven to 0 when its enable is 1 and is otherwise left at z.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit time before the request (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: abort limit measured from the request (15 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  command byte offered.
- tx_data  in  8  command byte; sampled only when tx_valid & tx_ready.
- tx_ready  out  1  idle and able to accept a byte.
- done  out  1  one-cycle pulse when a transfer ends.
- error  out  1  valid with done: 1 = no ack or timeout.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

## Operation
- Input conditioning: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. A third flop on the clock detects falling edges (previous 1, current 0).
- On accept: latch the frame {stop=1, parity=~^tx_data, tx_data[7:0]}, 10 bits, LSB first after the start bit. Then enter INHIBIT.
- States:
  - IDLE: both oe = 0, tx_ready = 1. On tx_valid → INHIBIT.
  - INHIBIT: clk_oe = 1, dat_oe = 0 for INHIBIT_CYCLES cycles → REQUEST.
  - REQUEST: clk_oe = 1, dat_oe = 1 (start bit) for 1 cycle. Clear the bit counter and the timeout counter → SEND.
  - SEND: clk_oe = 0, dat_oe = ~current_bit.
    - Falling edges 1–8 present data bits 0–7.
    - Edge 9 presents parity.
    - Edge 10 presents the stop bit (dat_oe = 0) → ACK.
  - ACK: on the next falling edge (11th), sample the synced data. 0 = ack, 1 = nack (latch error = 1). → WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk = 1 and dat = 1 on the same cycle. Pulse done with the latched error → IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, a counter increments every cycle. On reaching TIMEOUT_CYCLES:
  - both oe go 0 on the next cycle;
  - done = 1 and error = 1 are pulsed;
  - the block returns to IDLE.
- tx_valid while not ready is ignored; no queuing.
- A falling edge seen in IDLE, INHIBIT or REQUEST is ignored. Device-to-host traffic is the receiver's job.
- Reset (any state): next cycle the state is IDLE, clk_oe = 0, dat_oe = 0, done = 0, error = 0, tx_ready = 1, and all counters are 0. No done pulse is generated for the aborted transfer.

## Timing
- Accept at cycle 0 (tx_valid & tx_ready high on that edge) → tx_ready = 0 and clk_oe = 1 from cycle 1.
- clk_oe stays high for INHIBIT_CYCLES + 1 cycles in total, the last cycle with dat_oe = 1. It is released at cycle INHIBIT_CYCLES + 2.
- Pin falling edge to FSM detection: 3 cycles. dat_oe is updated on the detection cycle + 1, so the pin changes 4 cycles after the device edge. This is well inside the ≥30 µs PS/2 low phase.
- done is a single-cycle pulse; error is valid only in that cycle and is 0 otherwise.
- tx_ready rises in the cycle after done. Back-to-back transfers are therefore separated by at least 1 idle cycle.
- Counter widths: $clog2(TIMEOUT_CYCLES+1) for timeout and inhibit (shared counter), 4 bits for edges.
- All outputs are registered; no combinational paths from input to output.

## Structure
- ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_RESP_ACK = 8'hFA;
  - the frame-length constant 11.
- Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detect. It is reused by the receiver.

## Test plan
All scenarios use INHIBIT_CYCLES = 20 and TIMEOUT_CYCLES = 2000, with a device model that toggles the clock with a 40-cycle half-period and samples data on rising edges.
- Send 0xED:
  - device-sampled bits are start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - device acks low → done = 1, error = 0;
  - tx_ready returns 1 on the next cycle.
- Send 0x00: bits are eight 0s, parity 1, stop 1; ack → done with error = 0.
- Send 0x03 with the device leaving data high at edge 11 → parity 1 observed; done = 1, error = 1 after the lines idle.
- Device never clocks after the request → exactly 2000 cycles after REQUEST both oe = 0, done = 1, error = 1.
- Reset pulsed after falling edge 4 of 0xFF → next cycle both oe = 0, tx_ready = 1, and no done pulse.
- tx_valid held high across a 0xED transfer with tx_data changed mid-frame → the frame carries only 0xED, and the second byte is accepted the cycle tx_ready returns.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, well-known command bytes and frame geometry.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic ps2_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 pins plus a falling-edge strobe on the clock line.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic [2:0] clk_q;
  logic [1:0] dat_q;

  // Flops reset to 1 (idle bus level) so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_q <= '1;
      dat_q <= '1;
    end else begin
      clk_q <= {clk_q[1:0], clk_in};
      dat_q <= {dat_q[0], dat_in};
    end
  end

  assign clk_s    = clk_q[1];
  assign dat_s    = dat_q[1];
  assign clk_fall = clk_q[2] & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one frame, check ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame;
  logic          nack;
  logic          clk_s, dat_s, clk_fall;

  ps2_sync_edge u_sync (
    .clk      (CLOCK_50),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      frame      <= '0;
      nack       <= 1'b0;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_ready && tx_valid) begin
            frame      <= {1'b1, ps2_parity(tx_data), tx_data};
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
            nack       <= 1'b0;
            state      <= INHIBIT;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            // Timeout window opens with the request cycle itself.
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= REQUEST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQUEST: begin
          ps2_clk_oe <= 1'b0;
          bit_cnt    <= '0;
          cnt        <= cnt + 1'b1;
          state      <= SEND;
        end
        SEND, ACK, WAIT_IDLE: begin
          if (cnt == TO_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b1;
            error      <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == SEND && clk_fall) begin
              ps2_dat_oe <= ~frame[bit_cnt];
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= ACK;
            end else if (state == ACK && clk_fall) begin
              nack  <= dat_s;
              state <= WAIT_IDLE;
            end else if (state == WAIT_IDLE && clk_s && dat_s) begin
              done  <= 1'b1;
              error <= nack;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model (40-cycle half period).
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int pass_cnt = 0;
  int total    = 0;

  int   done_seen = 0;
  logic done_err  = 1'b0;
  logic done_rdy  = 1'b0;
  logic rdy_after = 1'b0;
  logic prev_done = 1'b0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Records every done pulse, its error flag and tx_ready in that and the following cycle.
  always @(negedge CLOCK_50) begin
    prev_done <= done;
    if (prev_done) rdy_after <= tx_ready;
    if (done) begin
      done_seen <= done_seen + 1;
      done_err  <= error;
      done_rdy  <= tx_ready;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge CLOCK_50);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  // Counts clk_oe-low-forced cycles until the host releases clk with the start bit on dat.
  task automatic wait_request(output bit ok, output int n_inh);
    ok = 1'b0;
    n_inh = 0;
    for (int i = 0; i < INH + 200 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe) n_inh++;
      else if (ps2_dat_oe) ok = 1'b1;
    end
  endtask

  task automatic dev_edge(input logic dat_drive, output logic sampled);
    dev_clk = 1'b0;
    dev_dat = dat_drive;
    repeat (HALF) @(negedge CLOCK_50);
    dev_clk = 1'b1;
    sampled = ps2_dat_in;
    repeat (HALF) @(negedge CLOCK_50);
  endtask

  // bits[0] is the start bit, bits[10] the stop bit, as the device sees them.
  task automatic dev_frame(input int n_edges, input logic ack_low, output logic [10:0] bits);
    logic b;
    bits = '0;
    repeat (HALF) @(negedge CLOCK_50);
    bits[0] = ps2_dat_in;
    for (int i = 1; i <= n_edges && i <= 10; i++) begin
      dev_edge(1'b1, b);
      bits[i] = b;
    end
    if (n_edges == 11) begin
      dev_edge(ack_low ? 1'b0 : 1'b1, b);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (done_seen != n0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLOCK_50);
    total++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_dat_oe}); else pass_cnt++;
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else pass_cnt++;
    total++; if ({done, error} !== 2'b00) $display("FAIL reset_done_err got %b want 00", {done, error}); else pass_cnt++;
    reset = 1'b0;
    @(negedge CLOCK_50);
    total++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) $display("FAIL post_reset_idle got rdy=%b clk_oe=%b want 1,0", tx_ready, ps2_clk_oe); else pass_cnt++;
  endtask

  task automatic test_send_ed;
    bit ok, okd;
    int n_inh, n0;
    logic [10:0] bits;
    n0 = done_seen;
    start_tx(8'hED);
    total++; if ({tx_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b010) $display("FAIL accept_latency got %b want 010", {tx_ready, ps2_clk_oe, ps2_dat_oe}); else pass_cnt++;
    wait_request(ok, n_inh);
    total++; if (!ok) $display("FAIL ed_request got timeout want request"); else pass_cnt++;
    // Cycle 1 already seen in start_tx; cycles 2..INH+1 remain.
    total++; if (n_inh !== INH) $display("FAIL ed_inhibit_len got %0d want %0d", n_inh, INH); else pass_cnt++;
    dev_frame(11, 1'b1, bits);
    total++; if (bits !== 11'h7DA) $display("FAIL ed_bits got %h want 7da", bits); else pass_cnt++;
    wait_done(n0, okd);
    total++; if (!okd) $display("FAIL ed_done got none want pulse"); else pass_cnt++;
    total++; if (done_err !== 1'b0) $display("FAIL ed_error got %b want 0", done_err); else pass_cnt++;
    total++; if (done_rdy !== 1'b0) $display("FAIL ed_ready_at_done got %b want 0", done_rdy); else pass_cnt++;
    repeat (3) @(negedge CLOCK_50);
    total++; if (rdy_after !== 1'b1) $display("FAIL ed_ready_after got %b want 1", rdy_after); else pass_cnt++;
  endtask

  task automatic test_send_zero;
    bit ok, okd;
    int n_inh, n0;
    logic [10:0] bits;
    n0 = done_seen;
    start_tx(8'h00);
    wait_request(ok, n_inh);
    dev_frame(11, 1'b1, bits);
    total++; if (bits !== 11'h600) $display("FAIL zero_bits got %h want 600", bits); else pass_cnt++;
    wait_done(n0, okd);
    total++; if (!okd || done_err !== 1'b0) $display("FAIL zero_done got seen=%b err=%b want 1,0", okd, done_err); else pass_cnt++;
  endtask

  task automatic test_nack;
    bit ok, okd;
    int n_inh, n0;
    logic [10:0] bits;
    n0 = done_seen;
    start_tx(8'h03);
    wait_request(ok, n_inh);
    dev_frame(11, 1'b0, bits);
    total++; if (bits !== 11'h606) $display("FAIL nack_bits got %h want 606", bits); else pass_cnt++;
    wait_done(n0, okd);
    total++; if (!okd || done_err !== 1'b1) $display("FAIL nack_done got seen=%b err=%b want 1,1", okd, done_err); else pass_cnt++;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_timeout;
    bit   found;
    logic d1999, dat1999;
    logic [3:0] s2000;
    found = 1'b0;
    d1999 = 1'bx; dat1999 = 1'bx; s2000 = 'x;
    start_tx(8'hED);
    for (int i = 0; i < INH + 50 && !found; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe && ps2_dat_oe) found = 1'b1;
    end
    total++; if (!found) $display("FAIL to_request got none want request cycle"); else pass_cnt++;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLOCK_50);
      if (k == TMO - 1) begin d1999 = done; dat1999 = ps2_dat_oe; end
      if (k == TMO) s2000 = {done, error, ps2_clk_oe, ps2_dat_oe};
    end
    total++; if (d1999 !== 1'b0 || dat1999 !== 1'b1) $display("FAIL to_early got done=%b dat_oe=%b want 0,1", d1999, dat1999); else pass_cnt++;
    total++; if (s2000 !== 4'b1100) $display("FAIL to_abort got done,err,clk_oe,dat_oe=%b want 1100", s2000); else pass_cnt++;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    total++; if (tx_ready !== 1'b1 || done !== 1'b0) $display("FAIL to_idle got rdy=%b done=%b want 1,0", tx_ready, done); else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    bit ok;
    int n_inh, n0;
    logic [10:0] bits;
    start_tx(8'hFF);
    wait_request(ok, n_inh);
    dev_frame(4, 1'b1, bits);
    total++; if (bits[4:0] !== 5'b11110) $display("FAIL rst_partial_bits got %b want 11110", bits[4:0]); else pass_cnt++;
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    total++; if ({ps2_clk_oe, ps2_dat_oe, tx_ready, done} !== 4'b0010) $display("FAIL rst_abort got clk_oe,dat_oe,rdy,done=%b want 0010", {ps2_clk_oe, ps2_dat_oe, tx_ready, done}); else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    n0 = done_seen;
    repeat (300) @(negedge CLOCK_50);
    total++; if (done_seen !== n0) $display("FAIL rst_no_done got %0d pulses want 0", done_seen - n0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit ok, okd, got_done;
    int n_inh, n1;
    logic [10:0] bits;
    @(negedge CLOCK_50);
    tx_valid = 1'b1;
    tx_data  = 8'hED;
    fork
      begin
        repeat (400) @(negedge CLOCK_50);
        tx_data = 8'h55;
      end
    join_none
    wait_request(ok, n_inh);
    dev_frame(11, 1'b1, bits);
    total++; if (bits !== 11'h7DA) $display("FAIL b2b_first_bits got %h want 7da", bits); else pass_cnt++;
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge CLOCK_50);
      if (done) got_done = 1'b1;
    end
    total++; if (!got_done) $display("FAIL b2b_first_done got none want pulse"); else pass_cnt++;
    @(negedge CLOCK_50);
    total++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", tx_ready); else pass_cnt++;
    @(negedge CLOCK_50);
    total++; if ({tx_ready, ps2_clk_oe} !== 2'b01) $display("FAIL b2b_second_accept got rdy,clk_oe=%b want 01", {tx_ready, ps2_clk_oe}); else pass_cnt++;
    tx_valid = 1'b0;
    wait_request(ok, n_inh);
    n1 = done_seen;
    dev_frame(11, 1'b1, bits);
    total++; if (bits !== 11'h6AA) $display("FAIL b2b_second_bits got %h want 6aa", bits); else pass_cnt++;
    wait_done(n1, okd);
    total++; if (!okd || done_err !== 1'b0) $display("FAIL b2b_second_done got seen=%b err=%b want 1,0", okd, done_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_nack();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
